// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the writeback stage has priority, and multi-cycle results queue in a FIFO.
// Define WB_SCOREBOARD_EN to build the pending-destination scoreboard that drives busy1_o/busy2_o.
module wb_port_arbiter #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     pipe_we_i,
    input  logic [4:0]               pipe_rd_i,
    input  logic [XLEN-1:0]          pipe_wd_i,
    input  logic                     mc_valid_i,
    output logic                     mc_ready_o,
    input  logic [4:0]               mc_rd_i,
    input  logic [XLEN-1:0]          mc_wd_i,
    input  logic                     issue_valid_i,
    input  logic [4:0]               issue_rd_i,
    input  logic [4:0]               q_a1_i,
    input  logic [4:0]               q_a2_i,
    output logic                     busy1_o,
    output logic                     busy2_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic                     rf_we3_o,
    output logic [4:0]               rf_a3_o,
    output logic [XLEN-1:0]          rf_wd3_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]      rd_mem_q [DEPTH];
    logic [XLEN-1:0] wd_mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            rf_we3_q;
    logic [4:0]      rf_a3_q;
    logic [XLEN-1:0] rf_wd3_q;

    logic            pipe_act, mc_acc, push, pop, fifo_empty;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_wd;

    assign fifo_empty = (count_q == '0);
    assign mc_ready_o = !reset_i && (count_q != CW'(DEPTH));
    assign mc_acc     = mc_valid_i && mc_ready_o;
    // x0 results are handshaken but never stored.
    assign push       = mc_acc && (mc_rd_i != 5'd0);
    assign pipe_act   = pipe_we_i && (pipe_rd_i != 5'd0);
    assign pop        = !pipe_act && !fifo_empty;
    assign head_rd    = rd_mem_q[rd_ptr_q];
    assign head_wd    = wd_mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            rd_mem_q[wr_ptr_q] <= mc_rd_i;
            wd_mem_q[wr_ptr_q] <= mc_wd_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rf_we3_q <= 1'b0;
            rf_a3_q  <= '0;
            rf_wd3_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q  <= count_d;
            rf_we3_q <= pipe_act || pop;
            if (pipe_act) begin
                rf_a3_q  <= pipe_rd_i;
                rf_wd3_q <= pipe_wd_i;
            end else if (pop) begin
                rf_a3_q  <= head_rd;
                rf_wd3_q <= head_wd;
            end
        end
    end

    assign fifo_count_o = count_q;
    assign rf_we3_o     = rf_we3_q;
    assign rf_a3_o      = rf_a3_q;
    assign rf_wd3_o     = rf_wd3_q;

`ifdef WB_SCOREBOARD_EN
    logic [31:0] pend_q, pend_d;

    // Clear first so a same-edge re-issue of the popped destination stays pending.
    always_comb begin
        pend_d = pend_q;
        if (pop) pend_d[head_rd] = 1'b0;
        if (issue_valid_i && (issue_rd_i != 5'd0)) pend_d[issue_rd_i] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) pend_q <= '0;
        else         pend_q <= pend_d;
    end

    assign busy1_o = pend_q[q_a1_i] && (q_a1_i != 5'd0);
    assign busy2_o = pend_q[q_a2_i] && (q_a2_i != 5'd0);
`else
    logic unused_sb;
    assign unused_sb = ^{issue_valid_i, issue_rd_i, q_a1_i, q_a2_i};
    assign busy1_o   = 1'b0;
    assign busy2_o   = 1'b0;
`endif

endmodule
